// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle memory between the MIPS core and a
// debug/loader port. At most one access is granted per cycle, round-robin
// between the two requesters, with a bounded lock that lets debug hold the
// memory for up to MAXBURST consecutive grants while the core waits.
// Returned read data is tagged with the requester that issued the read.
//
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   c_req/c_we/c_adr/c_wdata       core request
//   c_gnt/c_stall                  core grant, core stall (c_req & ~c_gnt)
//   c_rdata/c_rvalid               core read return
//   d_req/d_we/d_lock/d_adr/d_wdata debug request, d_lock holds the grant
//   d_gnt/d_rdata/d_rvalid         debug grant and read return
//   m_en/m_we/m_adr/m_wdata        memory strobe and muxed access
//   m_rdata                        memory read data, one cycle after strobe
module mem_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAXBURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [WIDTH-1:0] c_adr,
  input  logic [WIDTH-1:0] c_wdata,
  output logic             c_gnt,
  output logic             c_stall,
  output logic [WIDTH-1:0] c_rdata,
  output logic             c_rvalid,
  input  logic             d_req,
  input  logic             d_we,
  input  logic             d_lock,
  input  logic [WIDTH-1:0] d_adr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_rvalid,
  output logic             m_en,
  output logic             m_we,
  output logic [WIDTH-1:0] m_adr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic [WIDTH-1:0] m_rdata
);

  localparam logic [1:0] OwnNone = 2'd0;
  localparam logic [1:0] OwnCore = 2'd1;
  localparam logic [1:0] OwnDbg  = 2'd2;
  localparam logic [3:0] MaxBurst = 4'(MAXBURST);

  logic       r_last;      // 0 = core granted last, 1 = debug
  logic [3:0] r_lockcnt;
  logic [1:0] r_rd_owner;

  logic       w_last_d;
  logic [3:0] w_lockcnt_d;
  logic [1:0] w_rd_owner_d;
  logic       w_locked;
  logic       w_gnt_c;
  logic       w_gnt_d;

  // A nonzero count means the previous cycle was a locked debug grant, so
  // the lock is live until the count reaches the burst limit.
  assign w_locked = (r_lockcnt != 4'd0) && (r_lockcnt < MaxBurst);

  always_comb begin
    w_gnt_c = 1'b0;
    w_gnt_d = 1'b0;
    // Grants are held off for as long as reset is asserted.
    if (reset) begin
      if (c_req && d_req) begin
        if (w_locked || !r_last) begin
          w_gnt_d = 1'b1;
        end else begin
          w_gnt_c = 1'b1;
        end
      end else begin
        w_gnt_c = c_req;
        w_gnt_d = d_req;
      end
    end
  end

  always_comb begin
    w_last_d     = r_last;
    w_lockcnt_d  = 4'd0;
    w_rd_owner_d = OwnNone;
    if (w_gnt_c) begin
      w_last_d = 1'b0;
      if (!c_we) w_rd_owner_d = OwnCore;
    end else if (w_gnt_d) begin
      w_last_d = 1'b1;
      if (!d_we) w_rd_owner_d = OwnDbg;
      if (d_lock) begin
        w_lockcnt_d = (r_lockcnt < MaxBurst) ? r_lockcnt + 4'd1 : r_lockcnt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last     <= 1'b1;
      r_lockcnt  <= 4'd0;
      r_rd_owner <= OwnNone;
    end else begin
      r_last     <= w_last_d;
      r_lockcnt  <= w_lockcnt_d;
      r_rd_owner <= w_rd_owner_d;
    end
  end

  always_comb begin
    m_en    = w_gnt_c | w_gnt_d;
    m_we    = 1'b0;
    m_adr   = '0;
    m_wdata = '0;
    if (w_gnt_c) begin
      m_we    = c_we;
      m_adr   = c_adr;
      m_wdata = c_wdata;
    end else if (w_gnt_d) begin
      m_we    = d_we;
      m_adr   = d_adr;
      m_wdata = d_wdata;
    end
  end

  assign c_gnt    = w_gnt_c;
  assign d_gnt    = w_gnt_d;
  assign c_stall  = c_req & ~w_gnt_c & reset;
  assign c_rvalid = (r_rd_owner == OwnCore);
  assign d_rvalid = (r_rd_owner == OwnDbg);
  assign c_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single MIPS data/instruction memory between the MIPS core and a debug/loader port. It sits between `mips` and the memory inside `mips_mem`. Each cycle it grants at most one single-cycle access under round-robin priority, with an optional bounded lock for debug bursts. It stalls the core while the core is waiting and routes returned read data to the requester that issued the read.

## Interface
- WIDTH, 8, data and address width (memory is 2^WIDTH words)
- MAXBURST, 4, maximum consecutive locked debug grants while the core is waiting (1..15)

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- c_req  in  1  core requests an access
- c_we  in  1  core access is a write
- c_adr  in  WIDTH  core address
- c_wdata  in  WIDTH  core write data
- c_gnt  out  1  core access performed this cycle
- c_stall  out  1  c_req & ~c_gnt
- c_rdata  out  WIDTH  read data to core
- c_rvalid  out  1  c_rdata valid (one-cycle pulse)
- d_req  in  1  debug port requests an access
- d_we  in  1  debug access is a write
- d_lock  in  1  debug port requests to hold the grant for its next access
- d_adr  in  WIDTH  debug address
- d_wdata  in  WIDTH  debug write data
- d_gnt  out  1  debug access performed this cycle
- d_rdata  out  WIDTH  read data to debug port
- d_rvalid  out  1  d_rdata valid (one-cycle pulse)
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_adr  out  WIDTH  memory address
- m_wdata  out  WIDTH  memory write data
- m_rdata  in  WIDTH  memory read data, valid one cycle after a read strobe

## Operation
- Registered state:
  - last: last granted requester; 0 = core, 1 = debug; reset value 1.
  - lockcnt: consecutive locked debug grants; 4 bits; reset value 0.
  - rd_owner: requester of the read in flight; 2 bits, none/core/debug; reset value none.
- Grant decision is combinational, from the requests and registered state:
  - Only one requester: grant it.
  - Both requesting, debug locked (previous grant was debug with d_lock=1 and lockcnt < MAXBURST): grant debug.
  - Otherwise: grant the requester other than last.
- Every grant updates last.
- lockcnt:
  - Increments on a debug grant with d_lock=1.
  - Clears on any core grant.
  - Clears on a debug grant with d_lock=0.
  - Clears on any cycle with no debug grant.
  - Saturates at MAXBURST.
- Memory outputs follow the granted requester: m_en=1, with m_we, m_adr and m_wdata muxed from that requester.
- With no grant, m_en=0 and m_we=0.
- A read grant sets rd_owner for the next cycle. In that cycle the owner's rvalid=1 and both rdata outputs carry m_rdata.
- A write produces no rvalid.
- Back-to-back reads pipeline: one read per cycle, one in flight at a time.
- Reset asserted, asynchronously:
  - Grants, m_en, m_we, rvalids and c_stall are forced to 0.
  - State returns to its reset values.
  - A read in flight is dropped; no rvalid follows.

## Timing
- Access latency: a write completes in its grant cycle. A read returns data one cycle after its grant.
- Handshake: a requester holds req, we, adr and wdata stable until gnt=1 is sampled at the rising edge. It may present a new request in the following cycle.
- Worst-case core wait while debug is locked: MAXBURST cycles. Without lock, the core waits at most 1 cycle.
- c_stall is combinational and drives the core's stall input in the same cycle.
- Outputs from reset release until the first request: all 0; rdata=m_rdata.

## Test plan
- Reset with c_req=1 held: c_gnt=0, m_en=0 during reset. On the first edge after release, c_gnt=1 (last=1 favours the core).
- Core-only read of 0xEE with memory holding 0x0D:
  - Cycle N: c_gnt=1, m_adr=0xEE.
  - Cycle N+1: c_rvalid=1, c_rdata=0x0D, d_rvalid=0.
- Both requesting continuously with d_lock=0: grants alternate core, debug, core, debug. c_stall is high only in debug cycles.
- Debug burst with d_lock=1 and the core requesting, MAXBURST=4: 4 consecutive d_gnt, then c_gnt=1, then debug again.
- Debug writes 0x0D to 0xEE, then the core reads 0xEE: m_we=1 and m_wdata=0x0D on the debug grant. The core read returns 0x0D.
- Reset asserted in the cycle after a debug read grant: d_rvalid stays 0. After release, rd_owner=none and lockcnt=0.
